tia_dl_bank: RTL

TIA_DL_BANK -- requirements
Module: tia_dl_bank

---
 rtl/tia_dl_bank_pkg.sv | 9 +
 rtl/tia_dl_prio.sv | 16 +
 rtl/tia_dl_bank.sv | 64 ++++++
 3 files changed

// File: rtl/tia_dl_bank_pkg.sv
// tia_dl_bank_pkg: shared defaults and index-width helper for the DL-family blocks
package tia_dl_bank_pkg;
  localparam int DL_CHANNELS = 15;
  localparam int DL_STICKY = 1;
  localparam int DL_CNT_W = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tia_dl_prio.sv
// tia_dl_prio: lowest-index priority encoder with any-bit flag
module tia_dl_prio import tia_dl_bank_pkg::*; #(
  parameter int N = DL_CHANNELS,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);
  // scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
    any = |req;
  end
endmodule

// File: rtl/tia_dl_bank.sv
// tia_dl_bank: two-phase sticky latch bank with first-hit record, commit counter and registered read
module tia_dl_bank import tia_dl_bank_pkg::*; #(
  parameter int CHANNELS = DL_CHANNELS,
  parameter int STICKY = DL_STICKY,
  parameter int CNT_W = DL_CNT_W,
  localparam int IW = idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                r,
  input  logic [CHANNELS-1:0] in,
  input  logic                phi1,
  input  logic                phi2,
  input  logic [CHANNELS-1:0] mask,
  input  logic                clr,
  input  logic [IW-1:0]       rd_sel,
  output logic [CHANNELS-1:0] out,
  output logic                rd_data,
  output logic [IW-1:0]       first_id,
  output logic                first_vld,
  output logic [CNT_W-1:0]    cnt
);
  logic [CHANNELS-1:0] sample;
  logic [CHANNELS-1:0] new_bits;
  logic [IW-1:0]       new_id;
  logic                any_new;
  logic [2**IW-1:0]    out_pad;
  assign new_bits = sample & mask & ~out;
  assign out_pad = (2**IW)'(out);
  tia_dl_prio #(.N(CHANNELS)) u_prio (
    .req(new_bits),
    .idx(new_id),
    .any(any_new)
  );
  // capture on phi1, commit on phi2; clr beats both, r beats everything
  always_ff @(posedge clk) begin
    if (r) begin
      out <= '0;
      sample <= '0;
      rd_data <= 1'b0;
      cnt <= '0;
      first_id <= '0;
      first_vld <= 1'b0;
    end else begin
      rd_data <= out_pad[rd_sel];
      if (clr) begin
        out <= '0;
        sample <= '0;
        cnt <= '0;
        first_id <= '0;
        first_vld <= 1'b0;
      end else begin
        if (phi1) sample <= (STICKY != 0) ? (in & ~out) : in;
        if (phi2) begin
          out <= (STICKY != 0) ? (out | (sample & mask)) : (sample & mask);
          if (any_new && cnt != '1) cnt <= cnt + 1'b1;
          if (any_new && !first_vld) begin
            first_id <= new_id;
            first_vld <= 1'b1;
          end
        end
      end
    end
  end
endmodule
